// File: rtl/matrix_frame_ctrl.sv
// Frame controller for the 16x16 column-scan LED display: parses SYNC/payload/checksum
// packets into a double-buffered frame store and drives the column scan.
module matrix_frame_ctrl #(
    parameter int          CLK_FRE      = 50,
    parameter int          SCAN_HZ      = 2000,
    parameter int          IDLE_TIMEOUT = 100000,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic        i_clk_sys,
    input  logic        i_rst,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_valid,
    input  logic        i_rx_parity_err,
    output logic [15:0] o_col_data,
    output logic [3:0]  o_curr_col,
    output logic        o_frame_swap,
    output logic        o_frame_err,
    output logic        o_busy
);

    localparam int SCAN_PERIOD = CLK_FRE * 1_000_000 / SCAN_HZ;
    localparam int DIV_W       = (SCAN_PERIOD > 2) ? $clog2(SCAN_PERIOD) : 1;
    localparam int GAP_W       = $clog2(IDLE_TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PAYLOAD,
        ST_CHECK
    } state_t;

    state_t             state_reg, state_next;
    logic [4:0]         idx_reg, idx_next;
    logic [7:0]         xor_reg, xor_next;
    logic [GAP_W-1:0]   gap_reg, gap_next;
    logic               swap_pending_reg;
    logic               front_sel_reg;
    logic [DIV_W-1:0]   div_reg;
    logic [3:0]         col_reg;
    logic [15:0]        col_data_reg;
    logic               frame_swap_reg;
    logic               frame_err_reg;

    logic               err_next;
    logic               pending_set;
    logic               wr_en;
    logic [5:0]         wr_addr;

    // Two 32-byte buffers; address bit 5 selects the buffer.
    logic [7:0]         frame_mem [0:63];

    logic               tick;
    logic [3:0]         col_next;
    logic               wrap_swap;
    logic               front_next;

    // ---------------------------------------------------------------
    // Receive FSM
    // ---------------------------------------------------------------
    always_ff @(posedge i_clk_sys) begin
        if (i_rst) begin
            state_reg     <= ST_IDLE;
            idx_reg       <= '0;
            xor_reg       <= '0;
            gap_reg       <= '0;
            frame_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            idx_reg       <= idx_next;
            xor_reg       <= xor_next;
            gap_reg       <= gap_next;
            frame_err_reg <= err_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        idx_next    = idx_reg;
        xor_next    = xor_reg;
        gap_next    = gap_reg;
        err_next    = 1'b0;
        pending_set = 1'b0;
        wr_en       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                gap_next = '0;
                if (i_rx_valid && !i_rx_parity_err && (i_rx_data == SYNC_BYTE)
                        && !swap_pending_reg) begin
                    state_next = ST_PAYLOAD;
                    idx_next   = '0;
                    xor_next   = '0;
                end
            end
            ST_PAYLOAD, ST_CHECK: begin
                if (i_rx_valid) begin
                    gap_next = '0;
                    if (i_rx_parity_err) begin
                        err_next   = 1'b1;
                        state_next = ST_IDLE;
                    end else if (state_reg == ST_PAYLOAD) begin
                        wr_en    = 1'b1;
                        xor_next = xor_reg ^ i_rx_data;
                        idx_next = idx_reg + 5'd1;
                        if (idx_reg == 5'd31) begin
                            state_next = ST_CHECK;
                        end
                    end else begin
                        state_next = ST_IDLE;
                        if (i_rx_data == xor_reg) begin
                            pending_set = 1'b1;
                        end else begin
                            err_next = 1'b1;
                        end
                    end
                end else if (gap_reg == GAP_W'(IDLE_TIMEOUT - 1)) begin
                    // The counter reaches IDLE_TIMEOUT on this edge.
                    err_next   = 1'b1;
                    state_next = ST_IDLE;
                    gap_next   = '0;
                end else begin
                    gap_next = gap_reg + GAP_W'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // Frame store: writes always target the back buffer
    // ---------------------------------------------------------------
    assign wr_addr = {~front_sel_reg, idx_reg};

    always_ff @(posedge i_clk_sys) begin
        if (i_rst) begin
            for (int i = 0; i < 64; i++) begin
                frame_mem[i] <= '0;
            end
        end else if (wr_en) begin
            frame_mem[wr_addr] <= i_rx_data;
        end
    end

    // ---------------------------------------------------------------
    // Column scan and buffer swap
    // ---------------------------------------------------------------
    assign tick       = (div_reg == DIV_W'(SCAN_PERIOD - 1));
    assign col_next   = col_reg + 4'd1;
    assign wrap_swap  = tick && (col_next == 4'd0) && swap_pending_reg;
    assign front_next = front_sel_reg ^ wrap_swap;

    always_ff @(posedge i_clk_sys) begin
        if (i_rst) begin
            div_reg          <= '0;
            col_reg          <= '0;
            col_data_reg     <= '0;
            front_sel_reg    <= 1'b0;
            swap_pending_reg <= 1'b0;
            frame_swap_reg   <= 1'b0;
        end else begin
            div_reg        <= tick ? '0 : div_reg + DIV_W'(1);
            front_sel_reg  <= front_next;
            frame_swap_reg <= wrap_swap;
            if (tick) begin
                col_reg      <= col_next;
                col_data_reg <= {frame_mem[{front_next, col_next, 1'b0}],
                                 frame_mem[{front_next, col_next, 1'b1}]};
            end
            // A checksum accepted on a wrap edge is not yet pending, so the set cannot race the clear.
            if (wrap_swap) begin
                swap_pending_reg <= 1'b0;
            end
            if (pending_set) begin
                swap_pending_reg <= 1'b1;
            end
        end
    end

    assign o_col_data   = col_data_reg;
    assign o_curr_col   = col_reg;
    assign o_frame_swap = frame_swap_reg;
    assign o_frame_err  = frame_err_reg;
    assign o_busy       = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_matrix_frame_ctrl.sv
// Directed self-checking bench for matrix_frame_ctrl with a shortened scan period
// (100 cycles) and timeout (200 cycles).
module tb_matrix_frame_ctrl;

    localparam int         PERIOD  = 100;
    localparam int         TIMEOUT = 200;
    localparam logic [7:0] SYNC    = 8'hA5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        rx_perr = 1'b0;
    logic [15:0] col_data;
    logic [3:0]  curr_col;
    logic        frame_swap;
    logic        frame_err;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int swap_cnt = 0;
    int err_cnt = 0;

    matrix_frame_ctrl #(
        .CLK_FRE      (1),
        .SCAN_HZ      (10000),
        .IDLE_TIMEOUT (TIMEOUT),
        .SYNC_BYTE    (SYNC)
    ) dut (
        .i_clk_sys       (clk),
        .i_rst           (rst),
        .i_rx_data       (rx_data),
        .i_rx_valid      (rx_valid),
        .i_rx_parity_err (rx_perr),
        .o_col_data      (col_data),
        .o_curr_col      (curr_col),
        .o_frame_swap    (frame_swap),
        .o_frame_err     (frame_err),
        .o_busy          (busy)
    );

    always #5 clk = ~clk;

    // Pulse counters sample on the rising edge, before the DUT updates.
    always @(posedge clk) begin
        if (frame_swap) swap_cnt <= swap_cnt + 1;
        if (frame_err)  err_cnt  <= err_cnt + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic perr);
        @(negedge clk);
        rx_data  = d;
        rx_valid = 1'b1;
        rx_perr  = perr;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_perr  = 1'b0;
    endtask

    task automatic send_frame(input string name, input logic [7:0] pat, input logic [7:0] csum,
                              input int perr_idx, input bit with_csum);
        send_byte(SYNC, 1'b0);
        for (int i = 0; i < 32; i++) begin
            if (i == perr_idx) begin
                send_byte(pat ^ 8'(i), 1'b1);
                $display("[tx] %s: sync + %0d bytes, parity error on byte %0d", name, i, i);
                return;
            end
            send_byte(pat ^ 8'(i), 1'b0);
        end
        if (with_csum) send_byte(csum, 1'b0);
        $display("[tx] %s: sync + 32 bytes pattern %02h, checksum %s %02h", name, pat,
                 with_csum ? "sent" : "held", csum);
    endtask

    task automatic wait_col(input logic [3:0] target, output bit ok);
        logic [3:0] prev;
        prev = curr_col;
        ok = 1'b0;
        for (int n = 0; n < 17 * PERIOD; n++) begin
            @(negedge clk);
            if (curr_col == target && prev != target) begin
                ok = 1'b1;
                break;
            end
            prev = curr_col;
        end
    endtask

    task automatic wait_swap(output bit ok, output int n);
        ok = 1'b0;
        n = 0;
        while (n < 17 * PERIOD) begin
            @(negedge clk);
            n++;
            if (frame_swap) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic count_change(output int n);
        logic [3:0] prev;
        prev = curr_col;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (curr_col == prev && n < 2 * PERIOD);
    endtask

    initial begin
        bit ok;
        int n;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_col", 32'(curr_col), 0);
        check("rst_data", 32'(col_data), 0);
        check("rst_swap", 32'(frame_swap), 0);
        check("rst_err", 32'(frame_err), 0);
        check("rst_busy", 32'(busy), 0);
        rst = 1'b0;
        $display("[reset] released");

        // Idle scan: 16 column steps, one per period, blank data
        for (int i = 0; i < 16; i++) begin
            count_change(n);
            check("idle_period", 32'(n), PERIOD);
            check("idle_col", 32'(curr_col), 32'((i + 1) % 16));
            check("idle_data", 32'(col_data), 0);
        end
        check("idle_no_swap", 32'(swap_cnt), 0);
        $display("[scan] idle scan of 16 columns done");

        // Good frame 00..1F, checksum 00
        send_frame("good", 8'h00, 8'h00, -1, 1'b1);
        check("good_busy", 32'(busy), 0);
        wait_swap(ok, n);
        check("good_swap_seen", 32'(ok), 1);
        check("good_col0", 32'(curr_col), 0);
        check("good_data0", 32'(col_data), 32'h0001);
        @(negedge clk);
        check("good_swap_width", 32'(frame_swap), 0);
        wait_col(4'd15, ok);
        check("good_col15_seen", 32'(ok), 1);
        check("good_data15", 32'(col_data), 32'h1E1F);
        check("good_no_err", 32'(err_cnt), 0);

        // Bad checksum
        send_frame("bad_csum", 8'h40, 8'hFF, -1, 1'b1);
        check("bad_err", 32'(frame_err), 1);
        check("bad_busy", 32'(busy), 0);
        @(negedge clk);
        check("bad_err_width", 32'(frame_err), 0);
        wait_col(4'd0, ok);
        check("bad_wrap_seen", 32'(ok), 1);
        check("bad_data0", 32'(col_data), 32'h0001);
        check("bad_no_swap", 32'(swap_cnt), 1);
        check("bad_err_cnt", 32'(err_cnt), 1);

        // Parity abort on byte 10, then an immediate good frame
        send_frame("parity", 8'h00, 8'h00, 10, 1'b1);
        check("par_err", 32'(frame_err), 1);
        check("par_busy", 32'(busy), 0);
        send_frame("after_parity", 8'hF0, 8'h00, -1, 1'b1);
        wait_swap(ok, n);
        check("par_swap_seen", 32'(ok), 1);
        check("par_data0", 32'(col_data), 32'hF0F1);
        wait_col(4'd15, ok);
        check("par_data15", 32'(col_data), 32'hEEEF);

        // Timeout after sync + 5 payload bytes
        send_byte(SYNC, 1'b0);
        check("to_busy_rise", 32'(busy), 1);
        for (int i = 0; i < 5; i++) send_byte(8'(i), 1'b0);
        n = 0;
        while (!frame_err && n < TIMEOUT + 10) begin
            @(negedge clk);
            n++;
        end
        check("to_cycles", 32'(n), TIMEOUT);
        check("to_busy_fall", 32'(busy), 0);
        $display("[tx] timeout: sync + 5 bytes, idle for %0d cycles", n);
        @(negedge clk);
        check("to_err_cnt", 32'(err_cnt), 3);

        // Checksum lands exactly on a 15->0 wrap tick
        wait_col(4'd14, ok);
        check("wrap_col14_seen", 32'(ok), 1);
        send_frame("wrap", 8'h00, 8'h00, -1, 1'b0);
        wait_col(4'd15, ok);
        check("wrap_col15_seen", 32'(ok), 1);
        repeat (98) @(negedge clk);
        send_byte(8'h00, 1'b0);
        check("wrap_col0", 32'(curr_col), 0);
        check("wrap_no_swap_now", 32'(frame_swap), 0);
        check("wrap_data_old", 32'(col_data), 32'hF0F1);
        wait_swap(ok, n);
        check("wrap_swap_seen", 32'(ok), 1);
        check("wrap_swap_delay", 32'(n), 16 * PERIOD);
        check("wrap_data0", 32'(col_data), 32'h0001);

        // SYNC while a swap is pending is ignored
        send_frame("pending", 8'hF0, 8'h00, -1, 1'b1);
        send_byte(SYNC, 1'b0);
        check("pend_sync_busy", 32'(busy), 0);
        send_byte(8'h11, 1'b0);
        check("pend_byte_busy", 32'(busy), 0);
        wait_swap(ok, n);
        check("pend_swap_seen", 32'(ok), 1);
        check("pend_data0", 32'(col_data), 32'hF0F1);

        // Reset mid-packet
        send_byte(SYNC, 1'b0);
        for (int i = 0; i < 5; i++) send_byte(8'h55, 1'b0);
        check("mid_busy", 32'(busy), 1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("mid_rst_col", 32'(curr_col), 0);
        check("mid_rst_data", 32'(col_data), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_err", 32'(frame_err), 0);
        check("mid_rst_swap", 32'(frame_swap), 0);
        rst = 1'b0;
        $display("[reset] mid-packet reset released");
        wait_col(4'd15, ok);
        check("mid_col15_seen", 32'(ok), 1);
        check("mid_data15_clear", 32'(col_data), 0);
        check("final_err_cnt", 32'(err_cnt), 3);
        check("final_swap_cnt", 32'(swap_cnt), 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/matrix_frame_ctrl.md
# matrix_frame_ctrl

Frame controller for the 16×16 LED column-scan display. It sits between the UART receiver and the column drivers. It parses framed packets from the UART byte stream and writes the payload into a double-buffered 32-byte frame store. It swaps buffers only at a scan frame boundary, so a partially loaded image is never displayed. It also generates the column scan.

## Interface
Parameters:
- CLK_FRE, 50: system clock in MHz.
- SCAN_HZ, 2000: column advance rate in Hz. Scan tick period is CLK_FRE*1_000_000/SCAN_HZ cycles (default 25000).
- IDLE_TIMEOUT, 100000: maximum gap in cycles between bytes inside a packet before it is aborted.
- SYNC_BYTE, 8'hA5: packet start marker.

Ports:
- i_clk_sys  in  1  system clock; everything is on its rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_rx_data  in  8  received UART byte; valid only while i_rx_valid is high.
- i_rx_valid  in  1  one-cycle strobe per received byte.
- i_rx_parity_err  in  1  parity failure flag for the current byte; qualified by i_rx_valid.
- o_col_data  out  16  display data for o_curr_col, laid out as {byte[2c], byte[2c+1]}.
- o_curr_col  out  4  currently driven column.
- o_frame_swap  out  1  one-cycle pulse when a new frame becomes visible.
- o_frame_err  out  1  one-cycle pulse when a packet is aborted.
- o_busy  out  1  high while a packet is being received (state is not IDLE).

## Operation
- **Packet format:** SYNC_BYTE, then 32 payload bytes (index 0..31), then 1 checksum byte. The checksum is the XOR of all 32 payload bytes.
- **Frame store:** two 32×8 buffers. The front buffer (selected by register `front_sel`) is displayed; the back buffer is written.
- **Receive FSM states:** IDLE, PAYLOAD, CHECK.
  - IDLE, byte == SYNC_BYTE, no parity error, swap_pending == 0: go to PAYLOAD; clear byte index and running XOR.
  - IDLE, any other byte: ignored. Parity errors in IDLE are ignored and do not pulse o_frame_err. A SYNC byte arriving while swap_pending == 1 is also ignored.
  - PAYLOAD, valid byte: write back[idx]; XOR it into the running XOR; increment idx. After idx 31 is written, go to CHECK.
  - CHECK, valid byte:
    - If it equals the running XOR: set swap_pending and return to IDLE.
    - Otherwise: pulse o_frame_err and return to IDLE. The back buffer contents are don't-care.
  - PAYLOAD or CHECK, byte with i_rx_parity_err: pulse o_frame_err and return to IDLE. The byte is not written.
  - PAYLOAD or CHECK, gap counter reaches IDLE_TIMEOUT: pulse o_frame_err and return to IDLE. The gap counter clears on every i_rx_valid and counts only outside IDLE.
- **Scan:**
  - A divider produces a one-cycle tick every scan period.
  - On each tick, o_curr_col advances by 1 and wraps from 15 to 0.
  - On the same edge, o_col_data is loaded from the front buffer at the new column, so column and data always change together.
- **Swap:** on a tick where the next column is 0 and swap_pending == 1:
  - toggle front_sel;
  - clear swap_pending;
  - pulse o_frame_swap;
  - load o_col_data from the new front buffer, column 0.

## Timing
- **Reset (i_rst high on a clock edge):**
  - state IDLE; idx 0; XOR 0; swap_pending 0; front_sel 0.
  - divider 0; o_curr_col 0; o_col_data 0.
  - o_frame_swap 0; o_frame_err 0; o_busy 0.
  - Both buffers cleared to 0.
  - Reset mid-packet discards the packet without an error pulse.
- **Errors:** o_frame_err rises the cycle after the offending i_rx_valid, or the cycle after the timeout count is reached.
- **o_busy:** rises the cycle after an accepted SYNC byte. It falls the cycle after the checksum byte, error, or timeout.
- **swap_pending:** set the cycle after a good checksum byte.
- **Checksum accepted on the same edge as a wrap tick:** swap_pending is not yet visible, so the swap happens at the following wrap, 16 ticks later.
- **Worst-case swap latency:** 16 ticks (8 ms at defaults).
- **Non-overlap:** o_frame_swap and o_frame_err are never high on the same cycle as a reset.
- **Write width:** at most one back-buffer write per cycle. Read and write never address the same buffer.

## Test plan
- **Idle scan:** reset, then no input → o_curr_col steps 0..15..0 every 25000 cycles; o_col_data stays 16'h0000; o_frame_swap never pulses.
- **Good frame:** send A5, payload 00..1F, checksum 00 → swap_pending set. At the next 15→0 wrap, o_frame_swap pulses once; col 0 shows 16'h0001 and col 15 shows 16'h1E1F.
- **Bad checksum:** send A5, payload 00..1F, checksum FF → o_frame_err pulses one cycle after the checksum byte; display is unchanged; no swap.
- **Parity abort:** parity error on payload byte 10 → o_frame_err pulses; o_busy falls. An immediately following good frame is accepted and displayed.
- **Timeout:** send A5 plus 5 payload bytes, then stop → o_frame_err pulses IDLE_TIMEOUT cycles after the last byte; state returns to IDLE.
- **Pending interactions:**
  - Good checksum lands on a wrap tick → swap occurs 16 ticks later.
  - A5 sent while swap is pending → ignored, o_busy stays 0.
  - Reset asserted mid-packet → all outputs return to their reset values.
